// File: rtl/prog_stream_loader.sv
// Program-image loader: assembles a framed byte stream (sync, length, payload, checksum)
// into 16-bit program-memory writes and reports done/error status.
module prog_stream_loader #(
    parameter int          ADDR_WIDTH     = 16,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH-1:0] words_loaded
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_DATA_LO = 3'd4;
    localparam logic [2:0] S_CKSUM   = 3'd5;

    localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     MAX_WORDS = 32'(2 ** (ADDR_WIDTH - 1));

    logic [2:0]       state;
    logic [15:0]      frame_len;
    logic [7:0]       hold_hi;
    logic [7:0]       acc;
    logic [TMO_W-1:0] tmo_cnt;
    logic [15:0]      len_now;

    assign busy    = (state != S_IDLE);
    assign len_now = {frame_len[15:8], rx_data};

    // The write strobe is registered on the low-byte edge, so it still fires
    // even if load_en drops or the frame aborts on the following clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            frame_len    <= '0;
            hold_hi      <= '0;
            acc          <= '0;
            tmo_cnt      <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            if (!load_en) begin
                state   <= S_IDLE;
                tmo_cnt <= '0;
            end else if (state != S_IDLE && tmo_cnt == TMO_LAST) begin
                err      <= 1'b1;
                err_code <= 2'b10;
                state    <= S_IDLE;
                tmo_cnt  <= '0;
            end else if (rx_valid) begin
                tmo_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            done         <= 1'b0;
                            err          <= 1'b0;
                            err_code     <= 2'b00;
                            words_loaded <= '0;
                            acc          <= '0;
                            state        <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        frame_len[15:8] <= rx_data;
                        state           <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        frame_len[7:0] <= rx_data;
                        if (32'(len_now) > MAX_WORDS) begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                            state    <= S_IDLE;
                        end else if (len_now == 16'd0) begin
                            state <= S_CKSUM;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        hold_hi <= rx_data;
                        acc     <= acc + rx_data;
                        state   <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        acc          <= acc + rx_data;
                        mem_we       <= 1'b1;
                        mem_wdata    <= {hold_hi, rx_data};
                        mem_addr     <= words_loaded << 1;
                        words_loaded <= words_loaded + ADDR_WIDTH'(1);
                        if (32'(words_loaded) + 32'd1 == 32'(frame_len)) begin
                            state <= S_CKSUM;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                    S_CKSUM: begin
                        if (rx_data == acc) begin
                            done <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

endmodule
